// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel programmable clock divider.
package clkdiv_pkg;

    localparam int NUM_CH_MAX = 16;
    localparam int DIV_W_DEF  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } clkdiv_state_t;

    // Holds DIV_W_DEF-bit fields; narrower DIV_W instances use the low bits.
    typedef struct packed {
        logic [DIV_W_DEF-1:0] div;
        logic [DIV_W_DEF-1:0] high;
    } clkdiv_cfg_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: IDLE/RUN FSM, period counter, active and shadow
// settings, and registered clkout/tick outputs.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DEF_DIV  = 2,
    parameter int DEF_HIGH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    input  logic [DIV_W-1:0] wr_high_i,
    output logic             clkout_o,
    output logic             tick_o,
    output logic             pend_o
);

    clkdiv_state_t    state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    clkdiv_cfg_t      act_q, act_d;
    clkdiv_cfg_t      shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             clkout_q, clkout_d;
    logic             tick_q, tick_d;

    logic [DIV_W-1:0] eff_div;
    logic             last;
    logic             restart;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        shd_d   = shd_q;
        pend_d  = pend_q;
        restart = 1'b0;

        // A programmed period of zero behaves as a period of one.
        eff_div = (act_q.div[DIV_W-1:0] == '0) ? DIV_W'(1) : act_q.div[DIV_W-1:0];
        last    = (cnt_q == eff_div - DIV_W'(1));

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_i) begin
                    state_d = RUN;
                    restart = 1'b1;
                end
            end
            RUN: begin
                if (sync_i || last) begin
                    restart = 1'b1;
                    if (!sync_i && !en_i) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Settings written before this edge take effect; a write on this edge waits.
        if (restart) begin
            cnt_d = '0;
            if (pend_q) begin
                act_d  = shd_q;
                pend_d = 1'b0;
            end
        end

        if (wr_i) begin
            shd_d.div  = DIV_W_DEF'(wr_div_i);
            shd_d.high = DIV_W_DEF'(wr_high_i);
            pend_d     = 1'b1;
        end

        clkout_d = (state_d == RUN) && (cnt_d < act_d.high[DIV_W-1:0]);
        tick_d   = (state_d == RUN) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            act_q.div  <= DIV_W_DEF'(DEF_DIV);
            act_q.high <= DIV_W_DEF'(DEF_HIGH);
            shd_q.div  <= DIV_W_DEF'(DEF_DIV);
            shd_q.high <= DIV_W_DEF'(DEF_HIGH);
            pend_q     <= 1'b0;
            clkout_q   <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            shd_q    <= shd_d;
            pend_q   <= pend_d;
            clkout_q <= clkout_d;
            tick_q   <= tick_d;
        end
    end

    assign clkout_o = clkout_q;
    assign tick_o   = tick_q;
    assign pend_o   = pend_q;

endmodule

// File: rtl/multi_clkdiv.sv
// Multi-channel runtime-programmable clock divider: decodes configuration
// writes, broadcasts sync and instantiates one clkdiv_chan per channel.
module multi_clkdiv
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DEF_DIV  = 2,
    parameter int DEF_HIGH = 1,
    parameter int CH_W     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    input  logic [DIV_W-1:0]  wr_high,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_hit;

        // Channel numbers at or above NUM_CH match no instance and are dropped.
        assign wr_hit = wr_en && (32'(wr_ch) == i);

        clkdiv_chan #(
            .DIV_W    (DIV_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .en_i      (en[i]),
            .sync_i    (sync),
            .wr_i      (wr_hit),
            .wr_div_i  (wr_div),
            .wr_high_i (wr_high),
            .clkout_o  (clkout[i]),
            .tick_o    (tick[i]),
            .pend_o    (pend[i])
        );
    end

endmodule

// File: doc/multi_clkdiv.md
Name: multi_clkdiv

Overview:
- Multi-channel, runtime-programmable clock divider. Each channel has its own period and high time.
- Each channel outputs a divided square wave (clkout) and a one-cycle period-start strobe (tick).
- New divide/duty settings are staged in shadow registers and applied only at a period boundary, so outputs never glitch.
- Feeds slow-clock enables to display scanning, UART baud, LED PWM and debounce logic. Everything stays in the clk domain; outputs are used as enables or low-speed clocks.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16)
- DIV_W, 16, width of period and high-time fields and of each counter
- DEF_DIV, 2, period in clk cycles loaded at reset
- DEF_HIGH, 1, high time loaded at reset
- CH_W, 2, channel-select width, max(1, clog2(NUM_CH))

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- en  in  NUM_CH  per-channel run enable
- sync  in  1  single-cycle pulse; realigns all running channels
- wr_en  in  1  configuration write strobe
- wr_ch  in  CH_W  target channel
- wr_div  in  DIV_W  new period in clk cycles (D)
- wr_high  in  DIV_W  new high time in clk cycles (H)
- clkout  out  NUM_CH  divided outputs, registered
- tick  out  NUM_CH  one-cycle strobe in the first cycle of each period, registered
- pend  out  NUM_CH  shadow values written but not yet applied

Interface rule: reset reset_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values, every channel:
  - state IDLE, cnt 0, clkout 0, tick 0, pend 0
  - active D = DEF_DIV, active H = DEF_HIGH; shadow = same values
- Per-channel FSM states: IDLE, RUN.
- IDLE:
  - Outputs held at clkout 0, tick 0; cnt held at 0.
  - When en is sampled 1 at an edge, the channel enters RUN at that edge.
  - At that same edge: if pend, shadow is copied to active and pend clears; cnt=0; tick=1; clkout=(0<H).
  - Latency from en rising to first tick is 1 clk.
- RUN:
  - cnt counts 0..D-1, then wraps.
  - Registered outputs follow the new cnt value: clkout=(cnt<H), tick=(cnt==0).
  - Resulting waveform: clkout high for the first H cycles of every D-cycle period.
- Boundary (RUN and cnt==D-1):
  - If pend: active takes shadow, pend clears; the new D/H govern the period that starts next.
  - If en==0 at the boundary: go to IDLE; clkout=0, tick=0.
  - Disable therefore always completes the current period with no truncated high pulse.
- Arithmetic and clamping:
  - D=0 is treated as D=1.
  - D=1 gives tick every cycle and clkout=(H>=1).
  - H>=D gives clkout constant 1; H=0 gives clkout constant 0. tick still toggles per period in both cases.
  - All comparisons are unsigned, DIV_W bits; no overflow is possible because cnt<=D-1.
- Writes:
  - With wr_en=1 and wr_ch<NUM_CH, wr_div/wr_high go to that channel's shadow and pend sets.
  - wr_ch>=NUM_CH is ignored.
  - A second write before the boundary overwrites the shadow; only the last value applies.
  - A write landing on the boundary edge is not applied at that boundary. It stays pending for the next boundary (or the next start from IDLE).
- sync:
  - Every channel in RUN restarts its period at the edge: cnt=0, tick=1, pend applied if set. This happens even mid-period and may shorten that period.
  - IDLE channels ignore sync.
  - sync at the same edge as en falling: the restart wins and the channel stays in RUN until the next boundary.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous); pending shadow values are lost.

Decomposition:
- Package clkdiv_pkg holds:
  - constants NUM_CH_MAX=16 and the DIV_W default
  - state encoding IDLE=1'b0, RUN=1'b1
  - a config struct {div, high}
- Sub-module clkdiv_chan: one channel containing the FSM, counter, active/shadow registers and output registers.
- The top level does wr_ch decode, broadcasts sync, and instantiates NUM_CH channels via generate.

Test Plan:
- Reset, write ch0 D=4 H=2, en[0]=1 -> after pend clears, clkout[0] = 1,1,0,0 repeating; tick[0] high every 4th cycle, aligned with the first 1.
- Ch0 running D=4 H=2, write D=3 H=1 at cnt=1 -> pend=1; remaining cycles at old D/H; next period 1,0,0; pend clears on the boundary edge.
- Write ch1 D=5 H=7, then D=5 H=0; also write D=0 -> clkout[1] constant 1, then constant 0; D=0 gives tick every cycle.
- Ch0 D=4, ch1 D=6, both running, pulse sync -> both tick on the next cycle; ch0 ticks every 4 cycles and ch1 every 6 from that point.
- Drop en[0] at cnt=1 with D=4 H=2 -> clkout finishes 0,0 (cnt 2,3), then IDLE; a write to wr_ch=NUM_CH has no effect.
- Assert reset_n=0 mid-high phase -> clkout, tick and pend go to 0 immediately; after release, en=1 gives period DEF_DIV, high DEF_HIGH.
